ddr_ca_iod_tx_ctrl: RTL and testbench
=====================================

Name: ddr_ca_iod_tx_ctrl

Overview:
- Parametrised fabric-side controller for a bank of DDR3 command/address output IODs (RAS_N, CAS_N, WE_N, address lanes), one IOD per lane.
- Registers 4:1-geared command words into per-lane TX_DATA/OE_DATA and drives idle levels between commands.
- Contains a per-lane delay-line sequencer: a training engine requests a tap value, and the block steps the IOD delay line there with MOVE/DIRECTION/LOAD pulses.
- Sits between the DDR3 controller/training logic and the IOD instances in PF_DDR3_C0_DDRPHY_BLK.

Parameters:
- LANES, 8, number of CA output lanes (IODs) driven.
- GEAR, 4, bits per lane per FAB_CLK cycle.
- DLY_W, 8, delay tap counter width.
- INIT_TAP, 1, tap value after reset or reload; matches IOD TX_DELAY_VAL.
- MAX_TAP, 127, highest legal requested tap.
- MOVE_GAP, 4, FAB_CLK cycles from one MOVE pulse to the next (>=2).

Ports:
- FAB_CLK  in  1  fabric clock; all logic on rising edge.
- TX_SYNC_RST  in  1  synchronous reset, active-high.
- CMD_VALID  in  1  command word valid.
- CMD_DATA  in  LANES*GEAR  lane l uses bits [l*GEAR +: GEAR].
- CMD_READY  out  1  command accepted when VALID&&READY.
- IDLE_LEVEL  in  LANES  per-lane level driven when no command is sent.
- TX_DATA  out  LANES*GEAR  to IOD TX_DATA.
- OE_DATA  out  LANES*GEAR  to IOD OE_DATA.
- DLY_REQ  in  1  start a delay operation; sampled only in IDLE.
- DLY_RELOAD  in  1  qualifies DLY_REQ: reload to INIT_TAP instead of stepping.
- DLY_LANE  in  clog2(LANES)  target lane.
- DLY_TARGET  in  DLY_W  requested tap.
- DLY_ACK  out  1  one-cycle pulse when the operation ends.
- DLY_ERR  out  1  valid with DLY_ACK; target illegal or lane out of range.
- DLY_TAP  out  DLY_W  current tap of DLY_LANE (combinational read of the tap array).
- DELAY_LINE_MOVE  out  LANES  per-IOD move pulse.
- DELAY_LINE_DIRECTION  out  LANES  1 = increment tap.
- DELAY_LINE_LOAD  out  LANES  per-IOD load pulse.
- DELAY_LINE_OUT_OF_RANGE  in  LANES  from the IODs.

Behaviour:
- Reset values:
  - TX_DATA = each lane's bits replicated from IDLE_LEVEL, sampled combinationally during reset.
  - OE_DATA = 0; CMD_READY = 0; DLY_ACK = DLY_ERR = 0.
  - All MOVE/DIRECTION/LOAD = 0; tap array = INIT_TAP; FSM = IDLE.
- OE_DATA goes all-ones in the first cycle after reset deasserts and stays all-ones. CA lanes are always driven.
- Datapath latency is 1 cycle:
  - Accepted CMD_DATA appears on TX_DATA on the next edge.
  - Otherwise TX_DATA = IDLE_LEVEL replicated GEAR times per lane.
- CMD_READY = 1 only when the FSM is in IDLE and not in reset. No command is accepted while a delay line is moving, which avoids glitched CA edges.
- A DLY_REQ that is high in the same cycle as an accepted command: the command is accepted and the FSM leaves IDLE on the same edge.
- FSM states: IDLE, CHECK, LOAD, MOVE, GAP, DONE.
  - IDLE: on DLY_REQ, latch lane, target and reload, then go to CHECK.
  - CHECK:
    - reload -> LOAD.
    - target > MAX_TAP -> DONE with err.
    - target == tap[lane] -> DONE, ok, no pulses.
    - otherwise DIRECTION[lane] = (target > tap) and go to MOVE.
  - LOAD: LOAD[lane] high for 1 cycle; tap[lane] = INIT_TAP; -> DONE.
  - MOVE: MOVE[lane] high for exactly 1 cycle; tap[lane] steps by ±1; -> GAP.
  - GAP: wait MOVE_GAP-1 cycles. Then:
    - OUT_OF_RANGE[lane] sampled high -> DONE with err; tap is still updated.
    - tap == target -> DONE ok.
    - otherwise -> MOVE.
  - DONE: DLY_ACK = 1 for 1 cycle and DLY_ERR = err; -> IDLE.
- DIRECTION[lane] is held stable from CHECK through DONE. Only the latched lane's pulses ever assert; all other lanes' bits stay 0.
- Tap arithmetic wraps modulo 2^DLY_W. Wrap cannot occur for legal targets.
- Reset mid-operation aborts immediately:
  - Pulses drop in the reset cycle.
  - No ACK is issued.
  - Taps return to INIT_TAP. The IODs are reset by the same reset tree.

Optional Feature:
- Macro: DDR_CA_2T_TIMING_EN.
- Defined (2T timing): each accepted command is held on TX_DATA for 2 consecutive cycles, and CMD_READY is 0 in the cycle after each acceptance. Back-to-back throughput is 1 command per 2 cycles.
- Undefined: 1T; a command may be accepted every cycle.

Test Plan:
- Reset with IDLE_LEVEL=8'hFF, then release -> TX_DATA all ones; OE_DATA 0 in the reset cycle and all ones from the next cycle; CMD_READY=1.
- Back-to-back commands CMD_DATA=32'h1234_5678 then 32'h9ABC_DEF0 -> each appears on TX_DATA 1 cycle after acceptance; idle pattern returns afterwards.
- DLY_REQ lane 3, target 5 (tap 1) -> 4 MOVE[3] pulses spaced 4 cycles, DIRECTION[3]=1 throughout, DLY_TAP=5, ACK with ERR=0; CMD_READY=0 for the whole operation.
- Lane 3 target 2 from tap 5 -> 3 pulses with DIRECTION[3]=0; then target 2 again -> ACK 2 cycles after REQ, no pulses.
- Target 200 -> ACK with ERR=1, no pulses. Lane 0 with OUT_OF_RANGE[0] forced high after the first move -> 1 pulse, ACK with ERR=1.
- DLY_RELOAD on lane 7 -> single LOAD[7] pulse and tap=1. Reset asserted during GAP -> no ACK, all pulses 0. With DDR_CA_2T_TIMING_EN: each command held 2 cycles, READY toggles 1/0.

Source files
------------

// File: rtl/ddr_ca_iod_tx_ctrl.sv
// DDR3 CA output IOD controller: geared command register plus per-lane delay-line tap sequencer.
// Build option DDR_CA_2T_TIMING_EN: hold every accepted command on TX_DATA for two cycles (2T timing).
module ddr_ca_iod_tx_ctrl #(
    parameter int LANES    = 8,
    parameter int GEAR     = 4,
    parameter int DLY_W    = 8,
    parameter int INIT_TAP = 1,
    parameter int MAX_TAP  = 127,
    parameter int MOVE_GAP = 4,
    localparam int LANE_W  = (LANES > 1) ? $clog2(LANES) : 1
) (
    input  logic                     FAB_CLK,
    input  logic                     TX_SYNC_RST,
    input  logic                     CMD_VALID,
    input  logic [LANES*GEAR-1:0]    CMD_DATA,
    output logic                     CMD_READY,
    input  logic [LANES-1:0]         IDLE_LEVEL,
    output logic [LANES*GEAR-1:0]    TX_DATA,
    output logic [LANES*GEAR-1:0]    OE_DATA,
    input  logic                     DLY_REQ,
    input  logic                     DLY_RELOAD,
    input  logic [LANE_W-1:0]        DLY_LANE,
    input  logic [DLY_W-1:0]         DLY_TARGET,
    output logic                     DLY_ACK,
    output logic                     DLY_ERR,
    output logic [DLY_W-1:0]         DLY_TAP,
    output logic [LANES-1:0]         DELAY_LINE_MOVE,
    output logic [LANES-1:0]         DELAY_LINE_DIRECTION,
    output logic [LANES-1:0]         DELAY_LINE_LOAD,
    input  logic [LANES-1:0]         DELAY_LINE_OUT_OF_RANGE
);
    localparam int GAP_W = (MOVE_GAP > 2) ? $clog2(MOVE_GAP - 1) : 1;

    typedef enum logic [2:0] {ST_IDLE, ST_CHECK, ST_LOAD, ST_MOVE, ST_GAP, ST_DONE} state_t;

    state_t                   state_q, state_d;
    logic [LANE_W-1:0]        lane_q, lane_d;
    logic [DLY_W-1:0]         tgt_q, tgt_d;
    logic                     reload_q, reload_d;
    logic                     dir_q, dir_d;
    logic                     err_q, err_d;
    logic [GAP_W-1:0]         gap_cnt_q, gap_cnt_d;
    logic [DLY_W-1:0]         tap_q [LANES];
    logic [DLY_W-1:0]         tap_d [LANES];
    logic [LANES*GEAR-1:0]    tx_data_q, tx_data_d;
    logic [LANES*GEAR-1:0]    idle_pattern;
    logic [DLY_W-1:0]         cur_tap;
    logic                     lane_ok, tgt_over, dir_calc, dir_active;
    logic                     cmd_ready, cmd_accept;

    genvar gi;
    for (gi = 0; gi < LANES; gi++) begin : g_idle
        assign idle_pattern[gi*GEAR +: GEAR] = {GEAR{IDLE_LEVEL[gi]}};
    end

    assign cur_tap  = tap_q[lane_q];
    assign lane_ok  = ({{(32-LANE_W){1'b0}}, lane_q} < 32'(LANES));
    assign tgt_over = ({{(32-DLY_W){1'b0}}, tgt_q} > 32'(MAX_TAP));
    assign dir_calc = !reload_q && (tgt_q > cur_tap);

    // Command path: no command is accepted while the sequencer owns a delay line.
    assign cmd_accept = CMD_VALID && cmd_ready;
`ifdef DDR_CA_2T_TIMING_EN
    logic hold_q, hold_d;
    assign hold_d    = cmd_accept;
    assign cmd_ready = (state_q == ST_IDLE) && !TX_SYNC_RST && !hold_q;
    assign tx_data_d = cmd_accept ? CMD_DATA : (hold_q ? tx_data_q : idle_pattern);
    always_ff @(posedge FAB_CLK) begin
        if (TX_SYNC_RST) begin
            hold_q <= 1'b0;
        end else begin
            hold_q <= hold_d;
        end
    end
`else
    assign cmd_ready = (state_q == ST_IDLE) && !TX_SYNC_RST;
    assign tx_data_d = cmd_accept ? CMD_DATA : idle_pattern;
`endif

    assign CMD_READY = cmd_ready;
    assign TX_DATA   = TX_SYNC_RST ? idle_pattern : tx_data_q;
    // CA lanes are driven continuously once out of reset.
    assign OE_DATA   = TX_SYNC_RST ? '0 : '1;
    assign DLY_TAP   = tap_q[DLY_LANE];
    assign DLY_ACK   = !TX_SYNC_RST && (state_q == ST_DONE);
    assign DLY_ERR   = !TX_SYNC_RST && (state_q == ST_DONE) && err_q;

    always_comb begin
        state_d   = state_q;
        lane_d    = lane_q;
        tgt_d     = tgt_q;
        reload_d  = reload_q;
        dir_d     = dir_q;
        err_d     = err_q;
        gap_cnt_d = gap_cnt_q;
        tap_d     = tap_q;
        case (state_q)
            ST_IDLE: begin
                if (DLY_REQ) begin
                    lane_d   = DLY_LANE;
                    tgt_d    = DLY_TARGET;
                    reload_d = DLY_RELOAD;
                    err_d    = 1'b0;
                    state_d  = ST_CHECK;
                end
            end
            ST_CHECK: begin
                dir_d = dir_calc;
                if (!lane_ok) begin
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end else if (reload_q) begin
                    state_d = ST_LOAD;
                end else if (tgt_over) begin
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end else if (tgt_q == cur_tap) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_MOVE;
                end
            end
            ST_LOAD: begin
                tap_d[lane_q] = DLY_W'(INIT_TAP);
                state_d       = ST_DONE;
            end
            ST_MOVE: begin
                tap_d[lane_q] = dir_q ? (cur_tap + 1'b1) : (cur_tap - 1'b1);
                gap_cnt_d     = '0;
                state_d       = ST_GAP;
            end
            ST_GAP: begin
                // Decide on the last gap cycle so MOVE pulses are exactly MOVE_GAP apart.
                if (gap_cnt_q == GAP_W'(MOVE_GAP - 2)) begin
                    if (DELAY_LINE_OUT_OF_RANGE[lane_q]) begin
                        err_d   = 1'b1;
                        state_d = ST_DONE;
                    end else if (cur_tap == tgt_q) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_MOVE;
                    end
                end else begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge FAB_CLK) begin
        if (TX_SYNC_RST) begin
            state_q   <= ST_IDLE;
            lane_q    <= '0;
            tgt_q     <= '0;
            reload_q  <= 1'b0;
            dir_q     <= 1'b0;
            err_q     <= 1'b0;
            gap_cnt_q <= '0;
            tx_data_q <= idle_pattern;
            for (int i = 0; i < LANES; i++) begin
                tap_q[i] <= DLY_W'(INIT_TAP);
            end
        end else begin
            state_q   <= state_d;
            lane_q    <= lane_d;
            tgt_q     <= tgt_d;
            reload_q  <= reload_d;
            dir_q     <= dir_d;
            err_q     <= err_d;
            gap_cnt_q <= gap_cnt_d;
            tx_data_q <= tx_data_d;
            for (int i = 0; i < LANES; i++) begin
                tap_q[i] <= tap_d[i];
            end
        end
    end

    // Direction is combinational in CHECK so it is already stable when the first MOVE fires.
    assign dir_active = (state_q == ST_CHECK) ? dir_calc
                      : ((state_q != ST_IDLE) && dir_q);

    for (gi = 0; gi < LANES; gi++) begin : g_lane
        logic sel;
        assign sel = !TX_SYNC_RST && (lane_q == LANE_W'(gi));
        assign DELAY_LINE_MOVE[gi]      = sel && (state_q == ST_MOVE);
        assign DELAY_LINE_LOAD[gi]      = sel && (state_q == ST_LOAD);
        assign DELAY_LINE_DIRECTION[gi] = sel && dir_active;
    end

endmodule

// File: tb/tb_ddr_ca_iod_tx_ctrl.sv
// Directed self-checking bench for ddr_ca_iod_tx_ctrl (default parameters; 1T or 2T build).
module tb_ddr_ca_iod_tx_ctrl;
    logic        clk = 1'b0;
    logic        srst;
    logic        cmd_valid;
    logic [31:0] cmd_data;
    logic        cmd_ready;
    logic [7:0]  idle_level;
    logic [31:0] tx_data;
    logic [31:0] oe_data;
    logic        dly_req;
    logic        dly_reload;
    logic [2:0]  dly_lane;
    logic [7:0]  dly_target;
    logic        dly_ack;
    logic        dly_err;
    logic [7:0]  dly_tap;
    logic [7:0]  dl_move;
    logic [7:0]  dl_dir;
    logic [7:0]  dl_load;
    logic [7:0]  dl_oor;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    ddr_ca_iod_tx_ctrl dut (
        .FAB_CLK                 (clk),
        .TX_SYNC_RST             (srst),
        .CMD_VALID               (cmd_valid),
        .CMD_DATA                (cmd_data),
        .CMD_READY               (cmd_ready),
        .IDLE_LEVEL              (idle_level),
        .TX_DATA                 (tx_data),
        .OE_DATA                 (oe_data),
        .DLY_REQ                 (dly_req),
        .DLY_RELOAD              (dly_reload),
        .DLY_LANE                (dly_lane),
        .DLY_TARGET              (dly_target),
        .DLY_ACK                 (dly_ack),
        .DLY_ERR                 (dly_err),
        .DLY_TAP                 (dly_tap),
        .DELAY_LINE_MOVE         (dl_move),
        .DELAY_LINE_DIRECTION    (dl_dir),
        .DELAY_LINE_LOAD         (dl_load),
        .DELAY_LINE_OUT_OF_RANGE (dl_oor)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Runs one delay operation; REQ is in cycle 0, cycle counts are relative to it.
    task automatic dly_op(input string tag, input logic [2:0] lane, input logic [7:0] tgt,
                          input logic reload, input bit force_oor, input logic exp_dir,
                          input int exp_moves, input int exp_loads, input int exp_ack_cyc,
                          input logic exp_err);
        int   moves = 0;
        int   loads = 0;
        int   ack_cyc = -1;
        int   last_move = -100;
        logic err = 1'b0;
        bit   stray = 0, rdy = 0, dir_bad = 0, spacing_bad = 0;
        logic [7:0] mask;
        mask       = 8'h01 << lane;
        dly_req    = 1'b1;
        dly_lane   = lane;
        dly_target = tgt;
        dly_reload = reload;
        step();
        dly_req    = 1'b0;
        dly_reload = 1'b0;
        for (int c = 1; c < 200; c++) begin
            #1;
            if (((dl_move | dl_load | dl_dir) & ~mask) != 8'h00) stray = 1;
            if ((dl_move & mask) != 8'h00) begin
                if (moves > 0 && (c - last_move) != 4) spacing_bad = 1;
                moves++;
                last_move = c;
            end
            if ((dl_load & mask) != 8'h00) loads++;
            if (dl_dir !== (exp_dir ? mask : 8'h00)) dir_bad = 1;
            if (cmd_ready) rdy = 1;
            dl_oor = (force_oor && moves > 0) ? mask : 8'h00;
            if (dly_ack) begin
                ack_cyc = c;
                err     = dly_err;
                break;
            end
            step();
        end
        $display("dly %s lane=%0d tgt=%0d reload=%0b moves=%0d loads=%0d ack_cyc=%0d err=%0b",
                 tag, lane, tgt, reload, moves, loads, ack_cyc, err);
        check_val({tag, "_ack_cyc"}, ack_cyc, exp_ack_cyc);
        check_val({tag, "_moves"}, moves, exp_moves);
        check_val({tag, "_loads"}, loads, exp_loads);
        check_val({tag, "_err"}, {31'd0, err}, {31'd0, exp_err});
        check_val({tag, "_stray_lane"}, {31'd0, stray}, 32'd0);
        check_val({tag, "_ready_busy"}, {31'd0, rdy}, 32'd0);
        check_val({tag, "_dir"}, {31'd0, dir_bad}, 32'd0);
        check_val({tag, "_spacing"}, {31'd0, spacing_bad}, 32'd0);
        dl_oor = 8'h00;
        step();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        srst = 1'b1; cmd_valid = 1'b0; cmd_data = '0; idle_level = 8'hFF;
        dly_req = 1'b0; dly_reload = 1'b0; dly_lane = '0; dly_target = '0; dl_oor = '0;
        repeat (3) step();
        #1;
        check_val("rst_tx", tx_data, 32'hFFFF_FFFF);
        check_val("rst_oe", oe_data, 32'h0);
        check_val("rst_ready", {31'd0, cmd_ready}, 32'd0);
        check_val("rst_ack", {31'd0, dly_ack}, 32'd0);
        check_val("rst_pulses", {8'd0, dl_move, dl_dir, dl_load}, 32'd0);
        step();
        srst = 1'b0;
        #1;
        check_val("rel_oe", oe_data, 32'hFFFF_FFFF);
        check_val("rel_ready", {31'd0, cmd_ready}, 32'd1);
        check_val("rel_tx", tx_data, 32'hFFFF_FFFF);
        check_val("rel_tap0", {24'd0, dly_tap}, 32'd1);
        step();

        // Back-to-back commands
        cmd_valid = 1'b1; cmd_data = 32'h1234_5678;
        #1;
        check_val("cmd0_ready", {31'd0, cmd_ready}, 32'd1);
        step();
        cmd_data = 32'h9ABC_DEF0;
        #1;
        check_val("cmd0_tx", tx_data, 32'h1234_5678);
`ifdef DDR_CA_2T_TIMING_EN
        check_val("cmd0_hold_ready", {31'd0, cmd_ready}, 32'd0);
        step();
        #1;
        check_val("cmd0_tx_hold", tx_data, 32'h1234_5678);
        check_val("cmd1_ready", {31'd0, cmd_ready}, 32'd1);
        step();
        cmd_valid = 1'b0;
        #1;
        check_val("cmd1_tx", tx_data, 32'h9ABC_DEF0);
        check_val("cmd1_hold_ready", {31'd0, cmd_ready}, 32'd0);
        step();
        #1;
        check_val("cmd1_tx_hold", tx_data, 32'h9ABC_DEF0);
`else
        check_val("cmd1_ready", {31'd0, cmd_ready}, 32'd1);
        step();
        cmd_valid = 1'b0;
        #1;
        check_val("cmd1_tx", tx_data, 32'h9ABC_DEF0);
`endif
        step();
        #1;
        check_val("cmd_idle_tx", tx_data, 32'hFFFF_FFFF);
        $display("cmd back-to-back done, tx=%h", tx_data);
        idle_level = 8'hA5;
        step();
        #1;
        check_val("idle_a5_tx", tx_data, 32'hF0F0_0F0F);
        idle_level = 8'hFF;
        step();

        // Delay line sequencing
        dly_op("up5", 3'd3, 8'd5, 1'b0, 0, 1'b1, 4, 0, 18, 1'b0);
        #1 check_val("up5_tap", {24'd0, dly_tap}, 32'd5);
        dly_op("down2", 3'd3, 8'd2, 1'b0, 0, 1'b0, 3, 0, 14, 1'b0);
        #1 check_val("down2_tap", {24'd0, dly_tap}, 32'd2);
        dly_op("same2", 3'd3, 8'd2, 1'b0, 0, 1'b0, 0, 0, 2, 1'b0);
        dly_op("illegal", 3'd3, 8'd200, 1'b0, 0, 1'b1, 0, 0, 2, 1'b1);
        #1 check_val("illegal_tap", {24'd0, dly_tap}, 32'd2);
        dly_op("oor", 3'd0, 8'd10, 1'b0, 1, 1'b1, 1, 0, 6, 1'b1);
        #1 check_val("oor_tap", {24'd0, dly_tap}, 32'd2);
        dly_op("pre7", 3'd7, 8'd3, 1'b0, 0, 1'b1, 2, 0, 10, 1'b0);
        #1 check_val("pre7_tap", {24'd0, dly_tap}, 32'd3);
        dly_op("reload7", 3'd7, 8'd50, 1'b1, 0, 1'b0, 0, 1, 3, 1'b0);
        #1 check_val("reload7_tap", {24'd0, dly_tap}, 32'd1);

        // Reset in the middle of a move sequence
        dly_req = 1'b1; dly_lane = 3'd5; dly_target = 8'd20;
        step();
        dly_req = 1'b0;
        step();
        #1 check_val("abort_move", {24'd0, dl_move}, 32'h20);
        step();
        srst = 1'b1;
        #1;
        check_val("abort_pulses", {8'd0, dl_move, dl_dir, dl_load}, 32'd0);
        check_val("abort_ack", {31'd0, dly_ack}, 32'd0);
        step();
        step();
        srst = 1'b0;
        begin
            int acks = 0;
            for (int c = 0; c < 24; c++) begin
                #1;
                if (dly_ack) acks++;
                step();
            end
            check_val("abort_no_ack", acks, 32'd0);
        end
        dly_lane = 3'd5;
        #1 check_val("abort_tap5", {24'd0, dly_tap}, 32'd1);
        dly_lane = 3'd3;
        #1 check_val("abort_tap3", {24'd0, dly_tap}, 32'd1);
        check_val("abort_ready", {31'd0, cmd_ready}, 32'd1);
        $display("reset abort done");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
